mult8_seq_ctrl: RTL and testbench

// - Sequencer that builds an 8x8 unsigned product by time-multiplexing one 4x4 unsigned array-multiplier core.
// - Issues four nibble partial products (aL*bL, aH*bL, aL*bH, aH*bH) and shift-accumulates them into a 16-bit result.
// - Sits between the tile's operand source and the result consumer; valid/ready on both sides.

---
 rtl/mult8_seq_ctrl_pkg.sv | 21 ++
 rtl/mult8_seq_ctrl_if.sv | 23 ++
 rtl/mult8_seq_ctrl_core.sv | 18 +
 rtl/mult8_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mult8_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-sequenced 8x8 multiplier.
package mult8_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_DONE
  } state_t;

  localparam int unsigned NIB_W = 4;

  // Left shift applied to each nibble partial product before accumulation
  localparam int unsigned SH_P0 = 0;
  localparam int unsigned SH_P1 = 4;
  localparam int unsigned SH_P2 = 4;
  localparam int unsigned SH_P3 = 8;

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result valid-ready bus between operand source, sequencer and consumer.
interface mult8_seq_ctrl_if #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [W_IN-1:0]   a;
  logic [W_IN-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [W_OUT-1:0]  product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mult8_seq_ctrl_core.sv
// Combinational 4x4 unsigned array multiplier core.
module mul4x4_core (
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);

  // Sum of shifted partial-product rows, one row per multiplier bit
  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (q[i]) begin
        p = p + ({4'b0000, m} << i);
      end
    end
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequencer building an 8x8 unsigned product from four passes of one 4x4 core.
module mult8_seq_ctrl
  import mult8_seq_ctrl_pkg::*;
#(
  parameter int unsigned W_IN      = 8,
  parameter int unsigned W_OUT     = 16,
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  mult8_seq_ctrl_if.slave   bus,
  output logic              busy
);

  state_t                 state, state_next;
  logic [W_IN-1:0]        a_q, b_q;
  logic [W_OUT-1:0]       acc, acc_next;
  logic [W_OUT-1:0]       product_q;
  logic                   load_product;
  logic [NIB_W-1:0]       core_m, core_q;
  logic [2*NIB_W-1:0]     pp;
  logic [W_OUT-1:0]       pp_ext;
  logic                   accept;
  logic                   zero_op;

  // Ready only depends on out_ready while a result is being handed off
  assign bus.in_ready  = !clr && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign zero_op       = (ZERO_SKIP != 0) && ((bus.a == '0) || (bus.b == '0));
  assign bus.out_valid = (state == ST_DONE);
  assign bus.product   = product_q;
  assign busy          = (state != ST_IDLE);

  // Route the latched operand nibbles for the current pass into the core
  always_comb begin
    core_m = '0;
    core_q = '0;
    case (state)
      ST_P0: begin core_m = a_q[NIB_W-1:0];       core_q = b_q[NIB_W-1:0];       end
      ST_P1: begin core_m = a_q[2*NIB_W-1:NIB_W]; core_q = b_q[NIB_W-1:0];       end
      ST_P2: begin core_m = a_q[NIB_W-1:0];       core_q = b_q[2*NIB_W-1:NIB_W]; end
      ST_P3: begin core_m = a_q[2*NIB_W-1:NIB_W]; core_q = b_q[2*NIB_W-1:NIB_W]; end
      default: ;
    endcase
  end

  mul4x4_core u_core (
    .m (core_m),
    .q (core_q),
    .p (pp)
  );

  assign pp_ext = {{(W_OUT-2*NIB_W){1'b0}}, pp};

  // Next state, accumulator update and product-load strobe
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    load_product = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          acc_next     = '0;
          state_next   = zero_op ? ST_DONE : ST_P0;
          load_product = zero_op;
        end
      end
      ST_P0: begin
        acc_next   = acc + (pp_ext << SH_P0);
        state_next = ST_P1;
      end
      ST_P1: begin
        acc_next   = acc + (pp_ext << SH_P1);
        state_next = ST_P2;
      end
      ST_P2: begin
        acc_next   = acc + (pp_ext << SH_P2);
        state_next = ST_P3;
      end
      ST_P3: begin
        acc_next     = acc + (pp_ext << SH_P3);
        state_next   = ST_DONE;
        load_product = 1'b1;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
          if (accept) begin
            acc_next     = '0;
            state_next   = zero_op ? ST_DONE : ST_P0;
            load_product = zero_op;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // accept is already blocked by clr through in_ready, so only the state needs forcing
    if (clr) begin
      state_next   = ST_IDLE;
      load_product = 1'b0;
    end
  end

  // State, operand, accumulator and product registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      product_q <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
      if (load_product) begin
        product_q <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed and random self-checking bench for mult8_seq_ctrl.
module tb_mult8_seq_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic busy, busy_nz;
  int   checks = 0;
  int   errors = 0;

  mult8_seq_ctrl_if #(.W_IN(8), .W_OUT(16)) bus ();
  mult8_seq_ctrl_if #(.W_IN(8), .W_OUT(16)) bus_nz ();

  assign bus_nz.in_valid  = bus.in_valid;
  assign bus_nz.a         = bus.a;
  assign bus_nz.b         = bus.b;
  assign bus_nz.out_ready = bus.out_ready;

  mult8_seq_ctrl #(.W_IN(8), .W_OUT(16), .ZERO_SKIP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus),
    .busy  (busy)
  );

  mult8_seq_ctrl #(.W_IN(8), .W_OUT(16), .ZERO_SKIP(0)) dut_nz (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus_nz),
    .busy  (busy_nz)
  );

  always #5 clk = ~clk;

  // Present one operand pair, return edges from accept (accept edge = 1) to out_valid
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output logic [15:0] prod);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = bus.product;
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_values;
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL rst_product: got %h expected 0000", bus.product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic [15:0] p;
    do_op(8'h0F, 8'h0F, lat, p);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    checks++; if (p !== 16'h00E1) begin errors++; $display("FAIL basic_product: got %h expected 00e1", p); end
  endtask

  task automatic test_corners;
    int lat;
    logic [15:0] p;
    do_op(8'hFF, 8'hFF, lat, p);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ffff_latency: got %0d expected 5", lat); end
    checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL ffff_product: got %h expected fe01", p); end
    do_op(8'h10, 8'h01, lat, p);
    checks++; if (p !== 16'h0010) begin errors++; $display("FAIL p1_path_product: got %h expected 0010", p); end
    do_op(8'h01, 8'h10, lat, p);
    checks++; if (p !== 16'h0010) begin errors++; $display("FAIL p2_path_product: got %h expected 0010", p); end
    do_op(8'hC0, 8'h30, lat, p);
    checks++; if (p !== 16'h2400) begin errors++; $display("FAIL p3_path_product: got %h expected 2400", p); end
    idle_cycles(3);
  endtask

  task automatic test_zero_skip;
    int l1, l2;
    logic [15:0] p1, p2;
    l1 = -1; l2 = -1; p1 = 16'hFFFF; p2 = 16'hFFFF;
    @(negedge clk);
    bus.a = 8'h00;
    bus.b = 8'hA5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (l1 < 0 && bus.out_valid === 1'b1) begin l1 = k; p1 = bus.product; end
      if (l2 < 0 && bus_nz.out_valid === 1'b1) begin l2 = k; p2 = bus_nz.product; end
      @(posedge clk);
      #1;
    end
    checks++; if (l1 !== 1) begin errors++; $display("FAIL zskip_latency: got %0d expected 1", l1); end
    checks++; if (p1 !== 16'h0000) begin errors++; $display("FAIL zskip_product: got %h expected 0000", p1); end
    checks++; if (l2 !== 5) begin errors++; $display("FAIL nozskip_latency: got %0d expected 5", l2); end
    checks++; if (p2 !== 16'h0000) begin errors++; $display("FAIL nozskip_product: got %h expected 0000", p2); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [15:0] p;
    @(negedge clk);
    bus.out_ready = 1'b0;
    do_op(8'h12, 8'h34, lat, p);
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_latency: got %0d expected 5", lat); end
    checks++; if (p !== 16'h03A8) begin errors++; $display("FAIL bp_product: got %h expected 03a8", p); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.product !== 16'h03A8) begin errors++; $display("FAIL bp_hold_product[%0d]: got %h expected 03a8", i, bus.product); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = 8'h02;
    bus.b = 8'h03;
    bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got out_valid=%b busy=%b expected 0/1", bus.out_valid, busy); end
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
    checks++; if (bus.product !== 16'h0006) begin errors++; $display("FAIL b2b_product: got %h expected 0006", bus.product); end
    idle_cycles(2);
  endtask

  task automatic test_abort;
    int lat;
    int seen;
    logic [15:0] p;
    @(negedge clk);
    bus.a = 8'hAB;
    bus.b = 8'hCD;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready_p1: got %b expected 0", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b out_valid=%b expected 0/0", busy, bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready_idle: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_release_ready: got %b expected 1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen); end
    checks++; if (bus.product !== 16'h0006) begin errors++; $display("FAIL abort_product_kept: got %h expected 0006", bus.product); end
    do_op(8'h03, 8'h05, lat, p);
    checks++; if (lat !== 5) begin errors++; $display("FAIL post_abort_latency: got %0d expected 5", lat); end
    checks++; if (p !== 16'h000F) begin errors++; $display("FAIL post_abort_product: got %h expected 000f", p); end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_op;
    int seen;
    @(negedge clk);
    bus.a = 8'hAB;
    bus.b = 8'hCD;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL midrst_product: got %h expected 0000", bus.product); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL postrst_state: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL postrst_no_partial: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_random;
    logic [15:0] q[$];
    logic [15:0] expv;
    logic [7:0]  ra, rb;
    logic        pending;
    int          sent, recvd, cyc;
    const int    n = 10000;
    sent = 0; recvd = 0; cyc = 0; pending = 1'b0; ra = '0; rb = '0;
    while (recvd < n && cyc < 80000) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(3) != 0);
      if (!pending && sent < n) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if ($urandom_range(15) == 0) ra = 8'h00;
        if ($urandom_range(15) == 0) rb = 8'h00;
        pending = 1'b1;
      end
      bus.in_valid = pending;
      bus.a = ra;
      bus.b = rb;
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got product %h expected no result", bus.product);
        end else begin
          expv = q.pop_front();
          if (bus.product !== expv) begin
            errors++;
            $display("FAIL rand_product[%0d]: got %h expected %h", recvd, bus.product, expv);
          end
          recvd++;
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        q.push_back(16'(ra) * 16'(rb));
        pending = 1'b0;
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (recvd !== n) begin errors++; $display("FAIL rand_count: got %0d results expected %0d", recvd, n); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    test_reset_values();
    test_basic();
    test_corners();
    test_zero_skip();
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
